// File: rtl/hier_pkg.sv
// hier_pkg: shared types and channel indices for the CORDIC scheduler slice
package hier_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} sched_state_t;
  localparam int CH_U = 0;
  localparam int CH_LL = 1;
  localparam int CH_LR = 2;
  localparam int NUM_CH = 3;
  localparam int COORD_W = 16;
  localparam int ANGLE_W = 32;
  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic [ANGLE_W-1:0] angle_t;
endpackage

// File: rtl/cordic_sched_if.sv
// cordic_sched_if: frame input, shared CORDIC port and per-channel output bundle
interface cordic_sched_if import hier_pkg::*; #(
  parameter int COORD_DEPTH = 16,
  parameter int ANGLE_DEPTH = 32
);
  logic frame_valid;
  logic frame_ready;
  logic signed [COORD_DEPTH-1:0] x_u, y_u, x_ll, y_ll, x_lr, y_lr;
  logic cordic_start;
  logic signed [COORD_DEPTH-1:0] cordic_x, cordic_y;
  logic [ANGLE_DEPTH-1:0] cordic_angle;
  logic cordic_rdy;
  logic [ANGLE_DEPTH-1:0] ch_angle;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_ready;
  logic busy;
  logic [15:0] frame_cnt;
  logic err;
  modport master (
    input frame_valid, x_u, y_u, x_ll, y_ll, x_lr, y_lr, cordic_angle, cordic_rdy, ch_ready,
    output frame_ready, cordic_start, cordic_x, cordic_y, ch_angle, ch_valid, busy, frame_cnt, err
  );
  modport slave (
    output frame_valid, x_u, y_u, x_ll, y_ll, x_lr, y_lr, cordic_angle, cordic_rdy, ch_ready,
    input frame_ready, cordic_start, cordic_x, cordic_y, ch_angle, ch_valid, busy, frame_cnt, err
  );
endinterface

// File: rtl/sched_wdog.sv
// sched_wdog: counts WAIT cycles and flags when LIMIT is reached without a result
module sched_wdog #(
  parameter int LIMIT = 36
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign timeout = en && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/cordic_sched.sv
// cordic_sched: shares one CORDIC across the U, LL, LR limb vectors of each frame.
// Define CORDIC_SCHED_TIMEOUT_EN to add the WAIT watchdog and sticky err.
module cordic_sched import hier_pkg::*; #(
  parameter int COORD_DEPTH = 16,
  parameter int ANGLE_DEPTH = 32,
  parameter int ITERATIONS = 16
) (
  input logic clk,
  input logic rst_n,
  cordic_sched_if.master bus
);
  sched_state_t state, nxt;
  logic [1:0] sel;
  logic [NUM_CH-1:0][COORD_DEPTH-1:0] xs, ys;
  logic timeout, last, xfer;
  assign last = sel == 2'(CH_LR);
  assign xfer = state == OUT && bus.ch_ready[sel];
`ifdef CORDIC_SCHED_TIMEOUT_EN
  sched_wdog #(.LIMIT(2 * ITERATIONS + 4)) u_wdog (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == ISSUE),
    .en(state == WAIT),
    .timeout(timeout)
  );
  // a result arriving on the deadline cycle wins over the watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.err <= 1'b0;
    else if (timeout && !bus.cordic_rdy) bus.err <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
      xs <= '0;
      ys <= '0;
      bus.ch_angle <= '0;
      bus.frame_cnt <= '0;
    end else begin
      if (state == IDLE && bus.frame_valid) begin
        sel <= '0;
        xs <= {bus.x_lr, bus.x_ll, bus.x_u};
        ys <= {bus.y_lr, bus.y_ll, bus.y_u};
      end
      if (state == WAIT && (bus.cordic_rdy || timeout)) bus.ch_angle <= bus.cordic_rdy ? bus.cordic_angle : '0;
      if (xfer) begin
        sel <= last ? sel : sel + 2'd1;
        bus.frame_cnt <= bus.frame_cnt + 16'(last);
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.frame_valid ? ISSUE : IDLE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (bus.cordic_rdy || timeout) ? OUT : WAIT;
      OUT:     nxt = xfer ? (last ? IDLE : ISSUE) : OUT;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.frame_ready = state == IDLE;
    bus.busy = state != IDLE;
    bus.cordic_start = state == ISSUE;
    bus.cordic_x = xs[sel];
    bus.cordic_y = ys[sel];
    bus.ch_valid = state == OUT ? 3'b001 << sel : '0;
  end
endmodule
